// File: rtl/sync_pulse_sched_pkg.sv
// ============================================================================
//  Module   : sync_pulse_sched_pkg
//  Purpose  : Shared types and defaults for the pulse scheduler.
//             SYNC_PULSE_SCHED_ACK_EN selects the WAIT_ACK hold state.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_pulse_sched_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int GAP_CYCLES_DEF = 8;

`ifdef SYNC_PULSE_SCHED_ACK_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;
`endif

  // Round-robin successor of a winner index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first set request at or after
//             ptr_i (wrapping), as one-hot grant and as binary index.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W:0] cand;

  // Scan from the farthest candidate back to ptr_i so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_REQ)) begin
        cand = cand - (IDX_W + 1)'(N_REQ);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        grant_o                    = '0;
        grant_o[cand[IDX_W-1:0]]   = 1'b1;
        idx_o                      = cand[IDX_W-1:0];
        any_o                      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_pulse_sched.sv
// ============================================================================
//  Module   : sync_pulse_sched
//  Purpose  : Latches one-cycle requests from N_REQ sources and issues them
//             one at a time to a shared pulse synchronizer, round-robin,
//             with a guard interval of GAP_CYCLES after every pulse.
//             Define SYNC_PULSE_SCHED_ACK_EN to add ack_in: the guard state
//             then also waits for a synchronizer acknowledge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_pulse_sched
  import sync_pulse_sched_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_pulse,
`ifdef SYNC_PULSE_SCHED_ACK_EN
  input  logic                     ack_in,
`endif
  output logic                     pulse_out,
  output logic [$clog2(N_REQ)-1:0] pulse_id,
  output logic [N_REQ-1:0]         pending,
  output logic                     busy,
  output logic [N_REQ-1:0]         overflow
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

`ifdef SYNC_PULSE_SCHED_ACK_EN
  localparam state_e ST_HOLD = ST_WAIT_ACK;
`else
  localparam state_e ST_HOLD = ST_GAP;
`endif

  state_e             state_q;
  logic               pulse_out_q;
  logic [IDX_W-1:0]   pulse_id_q;
  logic               busy_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [GAP_W-1:0]   cnt_q;
  logic [N_REQ-1:0]   winner_oh_q;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   overflow_q, overflow_d;
  logic [N_REQ-1:0]   clear_vec;
  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               hold_release;
`ifdef SYNC_PULSE_SCHED_ACK_EN
  logic               ack_seen_q;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (pending_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Pending set/clear and overflow detection; a re-request in the issue
  // cycle of the same requester simply re-arms it.
  always_comb begin
    clear_vec  = (state_q == ST_ISSUE) ? winner_oh_q : '0;
    pending_d  = (pending_q & ~clear_vec) | req_pulse;
    overflow_d = overflow_q | (req_pulse & pending_q & ~clear_vec);
  end

  // The hold state ends on its last counted cycle (and, with ack, once an ack was seen).
  always_comb begin
`ifdef SYNC_PULSE_SCHED_ACK_EN
    hold_release = (cnt_q == '0) && (ack_in || ack_seen_q);
`else
    hold_release = (cnt_q == '0);
`endif
  end

  // Request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Scheduler FSM with registered pulse, id and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pulse_out_q <= 1'b0;
      pulse_id_q  <= '0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      winner_oh_q <= '0;
`ifdef SYNC_PULSE_SCHED_ACK_EN
      ack_seen_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q     <= ST_ISSUE;
            pulse_out_q <= 1'b1;
            pulse_id_q  <= arb_idx;
            winner_oh_q <= arb_grant;
            busy_q      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q     <= ST_HOLD;
          pulse_out_q <= 1'b0;
          pulse_id_q  <= '0;
          winner_oh_q <= '0;
          busy_q      <= 1'b1;
          cnt_q       <= GAP_W'(GAP_CYCLES - 1);
          ptr_q       <= IDX_W'(rr_next(int'(pulse_id_q), N_REQ));
`ifdef SYNC_PULSE_SCHED_ACK_EN
          ack_seen_q  <= 1'b0;
`endif
        end
        ST_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - GAP_W'(1);
          end
`ifdef SYNC_PULSE_SCHED_ACK_EN
          ack_seen_q <= ack_seen_q | ack_in;
`endif
          if (hold_release) begin
`ifdef SYNC_PULSE_SCHED_ACK_EN
            ack_seen_q <= 1'b0;
`endif
            if (arb_any) begin
              state_q     <= ST_ISSUE;
              pulse_out_q <= 1'b1;
              pulse_id_q  <= arb_idx;
              winner_oh_q <= arb_grant;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          pulse_out_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_out = pulse_out_q;
  assign pulse_id  = pulse_id_q;
  assign pending   = pending_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_pulse_sched.sv
// ============================================================================
//  Module   : tb_sync_pulse_sched
//  Purpose  : Scoreboard bench for sync_pulse_sched (N_REQ=4, GAP_CYCLES=8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_pulse_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_pulse = '0;
  logic       pulse_out;
  logic [1:0] pulse_id;
  logic [3:0] pending;
  logic       busy;
  logic [3:0] overflow;
`ifdef SYNC_PULSE_SCHED_ACK_EN
  logic       ack_auto   = 1'b1;
  logic       ack_manual = 1'b0;
`endif

  sync_pulse_sched #(.N_REQ(4), .GAP_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_pulse (req_pulse),
`ifdef SYNC_PULSE_SCHED_ACK_EN
    .ack_in    (ack_auto | ack_manual),
`endif
    .pulse_out (pulse_out),
    .pulse_id  (pulse_id),
    .pending   (pending),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int base    = 0;
  int n_check = 0;
  int n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int cyc; } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp_v);
    n_check++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, exp_v, exp_v, cyc - base);
    end
  endtask

  // Monitor: every pulse must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (pulse_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_check++;
        n_fail++;
        $display("FAIL unexpected_pulse: got id %0d at cycle %0d, required no pulse",
                 pulse_id, cyc - base);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_id", int'(pulse_id), e.id);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int rel);
    while (cyc < base + rel) tick();
  endtask

  task automatic expect_pulse(input int id, input int rel);
    exp_t e;
    e.id  = id;
    e.cyc = base + rel;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_pulse = '0;
    repeat (3) tick();
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic end_test(input string name);
    chk(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    // Reset behaviour
    rst = 1'b1;
    repeat (2) tick();
    chk("in_reset_outputs", int'({pulse_out, pulse_id, pending, busy, overflow}), 0);
    do_reset();
    chk("post_reset_outputs", int'({pulse_out, pulse_id, pending, busy, overflow}), 0);
    at(1);
    chk("post_reset_outputs_c1", int'({pulse_out, pulse_id, pending, busy, overflow}), 0);

    // Single request from requester 2
    at(10); req_pulse = 4'b0100; expect_pulse(2, 12);
    at(11); req_pulse = '0;
    chk("single_pending_c11", int'(pending), 4'b0100);
    chk("single_busy_c11", int'(busy), 0);
    at(12);
    chk("single_busy_c12", int'(busy), 1);
    at(13);
    chk("single_pending_c13", int'(pending), 0);
    at(20);
    chk("single_busy_c20", int'(busy), 1);
    at(21);
    chk("single_busy_c21", int'(busy), 0);
    at(30);
    end_test("single_drained");

    // All four at once: round-robin, GAP_CYCLES+1 spacing
    do_reset();
    at(10); req_pulse = 4'b1111;
    expect_pulse(0, 12); expect_pulse(1, 21); expect_pulse(2, 30); expect_pulse(3, 39);
    at(11); req_pulse = '0;
    chk("all_pending_c11", int'(pending), 4'b1111);
    at(40);
    chk("all_overflow", int'(overflow), 0);
    at(50);
    chk("all_pending_end", int'(pending), 0);
    chk("all_busy_end", int'(busy), 0);
    end_test("all_drained");

    // Duplicate request from 1 while 0 is being served -> overflow
    do_reset();
    at(8);  req_pulse = 4'b0001; expect_pulse(0, 10);
    at(9);  req_pulse = '0;
    at(10); req_pulse = 4'b0010; expect_pulse(1, 19);
    at(11); req_pulse = 4'b0010;
    chk("ovf_pending_c11", int'(pending), 4'b0010);
    chk("ovf_overflow_c11", int'(overflow), 0);
    at(12); req_pulse = '0;
    chk("ovf_overflow_c12", int'(overflow), 4'b0010);
    at(30);
    chk("ovf_pending_end", int'(pending), 0);
    chk("ovf_sticky", int'(overflow), 4'b0010);
    end_test("ovf_drained");

    // Re-request in own ISSUE cycle re-arms without overflow
    do_reset();
    at(10); req_pulse = 4'b0001; expect_pulse(0, 12);
    at(11); req_pulse = '0;
    at(12); req_pulse = 4'b0001; expect_pulse(0, 21);
    at(13); req_pulse = '0;
    chk("rearm_pending_c13", int'(pending), 4'b0001);
    chk("rearm_overflow_c13", int'(overflow), 0);
    at(22);
    chk("rearm_pending_c22", int'(pending), 0);
    chk("rearm_overflow_c22", int'(overflow), 0);
    at(32);
    end_test("rearm_drained");

    // Reset mid-GAP discards pending requests
    do_reset();
    at(10); req_pulse = 4'b0001; expect_pulse(0, 12);
    at(11); req_pulse = '0;
    at(13); req_pulse = 4'b0110;
    at(14); req_pulse = '0;
    chk("abort_pending_c14", int'(pending), 4'b0110);
    chk("abort_busy_c14", int'(busy), 1);
    at(16); rst = 1'b1;
    at(17); rst = 1'b0;
    chk("abort_pending_c17", int'(pending), 0);
    chk("abort_busy_c17", int'(busy), 0);
    at(40);
    chk("abort_pending_c40", int'(pending), 0);
    end_test("abort_drained");

`ifdef SYNC_PULSE_SCHED_ACK_EN
    // Early ack is held until the minimum wait expires
    do_reset();
    ack_auto = 1'b0;
    at(10); req_pulse = 4'b0001; expect_pulse(0, 12);
    at(11); req_pulse = '0;
    at(14); req_pulse = 4'b0010; expect_pulse(1, 21);
    at(15); req_pulse = '0; ack_manual = 1'b1;
    at(16); ack_manual = 1'b0;
    at(20);
    chk("ack_pending_c20", int'(pending), 4'b0010);
    at(30);
    chk("ack_wait_busy", int'(busy), 1);
    end_test("ack_drained");
    ack_auto = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_pulse_sched.md
SYNC_PULSE_SCHED -- requirements
Module: sync_pulse_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of pulse requesters sharing one pulse-synchronizer channel; legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 8: number of guard cycles after each issued pulse; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req_pulse, input, N_REQ: one-cycle event pulse per requester.
REQ-006 Port pulse_out, output, 1: one-cycle pulse to the shared synchronizer signal_in.
REQ-007 Port pulse_id, output, $clog2(N_REQ): requester index of the current pulse_out; valid only while pulse_out=1.
REQ-008 Port pending, output, N_REQ: latched, not-yet-issued request per requester.
REQ-009 Port busy, output, 1: high in the ISSUE and GAP/WAIT_ACK states.
REQ-010 Port overflow, output, N_REQ: sticky flag per requester, set when a request is lost.

Function
REQ-011 A req_pulse[i] in cycle c SHALL set pending[i] from cycle c+1.
REQ-012 FSM states: IDLE, ISSUE, GAP. Transitions: IDLE->ISSUE when any pending bit is set; ISSUE->GAP always; GAP->ISSUE on the last gap cycle if any pending bit is set, otherwise GAP->IDLE.
REQ-013 In ISSUE, pulse_out SHALL be 1 for exactly one cycle, with pulse_id = winner; the winner's pending bit SHALL clear at the end of that cycle.
REQ-014 Arbitration is round-robin. The search starts at (last winner+1) mod N_REQ; the pointer is 0 after reset.
REQ-015 GAP SHALL last exactly GAP_CYCLES cycles, so consecutive pulse_out rising edges are spaced GAP_CYCLES+1 cycles apart when back-to-back.
REQ-016 End-to-end latency from an isolated req_pulse in cycle 0 with the FSM IDLE: pending in cycle 1, pulse_out in cycle 2.
REQ-017 A req_pulse[i] arriving while pending[i]=1 and pending[i] is not being cleared that cycle SHALL be dropped and SHALL set overflow[i].
REQ-018 A req_pulse[i] arriving in the same cycle pending[i] clears (ISSUE for i) SHALL leave pending[i]=1, with no overflow.
REQ-019 Simultaneous requests from several requesters SHALL all latch; they are issued one per ISSUE in round-robin order.
REQ-020 overflow[i] SHALL be cleared only by rst.
REQ-021 The gap counter is $clog2(GAP_CYCLES+1) bits wide, loads GAP_CYCLES-1 on entering GAP, and counts down to 0 with no wrap.

Reset
REQ-022 While rst=1: state=IDLE, pulse_out=0, pulse_id=0, pending=0, busy=0, overflow=0, RR pointer=0, gap counter=0.
REQ-023 An rst asserted mid-GAP or mid-ISSUE SHALL abort the operation; pending requests are discarded and no pulse_out is emitted in the cycle after rst deasserts.

Configuration
REQ-024 Macro SYNC_PULSE_SCHED_ACK_EN. When defined: an input port ack_in (1 bit, a synchronizer feedback pulse) is added, and the GAP state is replaced by WAIT_ACK, which exits on ack_in=1 with the same next-state rule as REQ-012. In this mode GAP_CYCLES acts as a minimum wait, and an ack_in arriving earlier is held until the count expires.
REQ-025 When SYNC_PULSE_SCHED_ACK_EN is undefined: there is no ack_in port and the behaviour is purely the fixed gap of REQ-015. An ack_in in IDLE or ISSUE (macro defined) SHALL be ignored.

Structure
REQ-026 Package sync_pulse_sched_pkg holds the FSM state enum (IDLE, ISSUE, GAP/WAIT_ACK) and the default constants N_REQ_DEF=4 and GAP_CYCLES_DEF=8.
REQ-027 Sub-module rr_arbiter: combinational round-robin winner from a request vector and pointer, plus a one-hot/index output; the FSM, counter and pending registers live in the top.

Verification (N_REQ=4, GAP_CYCLES=8)
REQ-028 rst held 3 cycles, then released -> all outputs 0 for the first cycle after release.
REQ-029 Single req_pulse[2] in cycle 10 -> pending[2] in cycle 11; pulse_out=1 with pulse_id=2 in cycle 12 only; busy in cycles 12..20; IDLE in cycle 21.
REQ-030 req_pulse=4'b1111 in cycle 10 -> pulse_out in cycles 12, 21, 30 and 39 with pulse_id 0, 1, 2, 3; overflow stays 0.
REQ-031 req_pulse[1] in cycles 10 and 11 while requester 0 is being served -> second request dropped, overflow[1]=1 from cycle 12, only one pulse issued with id 1.
REQ-032 req_pulse[0] again in the ISSUE cycle of id 0 -> pending[0] stays 1, second pulse with id 0 issued 9 cycles later, overflow[0]=0.
REQ-033 rst pulsed during GAP with pending=4'b0110 -> pending=0, no further pulse_out; with ACK_EN, ack_in in cycle 15 after a pulse in cycle 12 -> next ISSUE no earlier than cycle 21.
